// File: rtl/hsv_pwm_cycler_pkg.sv
// Shared types for the HSV PWM colour cycler: wheel sector and operating mode.
package hsv_pwm_pkg;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} sector_e;

    typedef enum logic [1:0] {
        HUE     = 2'd0,
        BREATHE = 2'd1,
        HOLD    = 2'd2,
        OFF     = 2'd3
    } mode_e;

    function automatic sector_e next_sector(input sector_e s);
        return (s == S5) ? S0 : sector_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/hsv_pwm_cycler_if.sv
// Control and LED-drive bundle of the colour cycler, as seen by a controller and the driver.
interface hsv_pwm_cycler_if;
    import hsv_pwm_pkg::*;

    mode_e mode;
    logic  pause;
    logic  rgb_r;
    logic  rgb_g;
    logic  rgb_b;
    logic  cycle_done;

    modport master (output mode, pause, input rgb_r, rgb_g, rgb_b, cycle_done);
    modport slave  (input mode, pause, output rgb_r, rgb_g, rgb_b, cycle_done);
endinterface

// File: rtl/hsv_pwm_cycler_pwm_channel.sv
// One LED channel: duty latched at frame wrap, compared against the frame count, registered.
module pwm_channel #(
    parameter int unsigned PWM_BITS   = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] frame,
    output logic                pwm_o
);
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] frame_nxt;
    logic                out_q, out_d;

    always_comb begin
        frame_nxt = frame + 1'b1;
        duty_d    = (frame == '1) ? duty : duty_q;
        // Compare with the upcoming frame value so the registered level lines up with frame
        out_d     = (frame_nxt < duty_d) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            out_q  <= ACTIVE_LOW;
        end else begin
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign pwm_o = out_q;

endmodule

// File: rtl/hsv_pwm_cycler.sv
// HSV colour-wheel LED driver: a prescaled phase walker feeding three PWM channels.
module hsv_pwm_cycler
    import hsv_pwm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned PERIOD_MS  = 1000,
    parameter int unsigned PWM_BITS   = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       pause,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic       cycle_done
);
    localparam int unsigned STEPS    = 2 ** PWM_BITS;
    localparam int unsigned TICK_DIV = (CLK_HZ / 1000 * PERIOD_MS) / (6 * STEPS);
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    if (TICK_DIV == 0) begin : g_tick_div_check
        $error("hsv_pwm_cycler: TICK_DIV must be at least 1");
    end

    mode_e               mode_s;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] idx_q, idx_d;
    sector_e             sec_q, sec_d;
    logic [PWM_BITS-1:0] frame_q, frame_d;
    logic                done_q, done_d;
    logic                run;
    logic [PWM_BITS-1:0] rise, fall;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;

    assign mode_s = mode_e'(mode);

    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        sec_d   = sec_q;
        done_d  = 1'b0;
        frame_d = frame_q + 1'b1;
        run     = !pause && (mode_s != HOLD);
        if (run) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = idx_q + 1'b1;
                if (idx_q == '1) begin
                    sec_d  = next_sector(sec_q);
                    done_d = (sec_q == S5);
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            idx_q   <= '0;
            sec_q   <= S0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sec_q   <= sec_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        rise   = idx_q;
        fall   = ~idx_q;
        if (mode_s == BREATHE) begin
            if (sec_q inside {S0, S2, S4}) begin
                duty_r = rise;
                duty_g = rise;
                duty_b = rise;
            end else begin
                duty_r = fall;
                duty_g = fall;
                duty_b = fall;
            end
        end else if (mode_s != OFF) begin
            case (sec_q)
                S0:      begin duty_r = '1;   duty_g = rise; end
                S1:      begin duty_r = fall; duty_g = '1;   end
                S2:      begin duty_g = '1;   duty_b = rise; end
                S3:      begin duty_g = fall; duty_b = '1;   end
                S4:      begin duty_r = rise; duty_b = '1;   end
                default: begin duty_r = '1;   duty_b = fall; end
            endcase
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_r (
        .clk(clk), .rst_n(rst_n), .duty(duty_r), .frame(frame_q), .pwm_o(RGB_R)
    );
    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_g (
        .clk(clk), .rst_n(rst_n), .duty(duty_g), .frame(frame_q), .pwm_o(RGB_G)
    );
    pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .duty(duty_b), .frame(frame_q), .pwm_o(RGB_B)
    );

    assign cycle_done = done_q;

endmodule

// File: tb/tb_hsv_pwm_cycler.sv
// Bench for hsv_pwm_cycler: cycle model pushes expected outputs, scenario tasks pop and compare.
module tb_hsv_pwm_cycler;
    import hsv_pwm_pkg::*;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    int         cyc  = 0;
    int         adv  = 0;
    int         fcnt = 0;
    logic [3:0] dr   = '0;
    logic [3:0] dg   = '0;
    logic [3:0] db   = '0;

    hsv_pwm_cycler_if if0 ();
    hsv_pwm_cycler_if if1 ();

    assign if1.mode  = if0.mode;
    assign if1.pause = if0.pause;

    hsv_pwm_cycler #(.CLK_HZ(96000), .PERIOD_MS(10), .PWM_BITS(4), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(if0.mode), .pause(if0.pause),
        .RGB_R(if0.rgb_r), .RGB_G(if0.rgb_g), .RGB_B(if0.rgb_b), .cycle_done(if0.cycle_done)
    );

    hsv_pwm_cycler #(.CLK_HZ(96000), .PERIOD_MS(10), .PWM_BITS(4), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .mode(if1.mode), .pause(if1.pause),
        .RGB_R(if1.rgb_r), .RGB_G(if1.rgb_g), .RGB_B(if1.rgb_b), .cycle_done(if1.cycle_done)
    );

    always #5 clk = ~clk;

    // Duties {R,G,B} for tick count n: 16 ticks per sector, six sectors per revolution.
    function automatic logic [11:0] wheel_duty(input int n, input mode_e m);
        int         sec;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [11:0] d;
        sec  = (n / 16) % 6;
        rise = 4'(n % 16);
        fall = 4'(15 - (n % 16));
        d    = 12'h000;
        if (m == BREATHE) begin
            d = (sec % 2 == 0) ? {rise, rise, rise} : {fall, fall, fall};
        end else if (m != OFF) begin
            case (sec)
                0:       d = {4'd15, rise, 4'd0};
                1:       d = {fall, 4'd15, 4'd0};
                2:       d = {4'd0, 4'd15, rise};
                3:       d = {4'd0, fall, 4'd15};
                4:       d = {rise, 4'd0, 4'd15};
                default: d = {4'd15, 4'd0, fall};
            endcase
        end
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int          na;
        int          nf;
        exp_t        e;
        logic [11:0] d;
        if (!rst_n) begin
            cyc  <= 0;
            adv  <= 0;
            fcnt <= 0;
            dr   <= '0;
            dg   <= '0;
            db   <= '0;
            exp_q.delete();
        end else begin
            d = {dr, dg, db};
            if (fcnt == 15) d = wheel_duty(adv / 10, if0.mode);
            na     = adv;
            e.done = 1'b0;
            if (!if0.pause && if0.mode != HOLD) begin
                na = adv + 1;
                if (na % 960 == 0) e.done = 1'b1;
            end
            nf  = (fcnt + 1) % 16;
            e.r = (nf < int'(d[11:8]));
            e.g = (nf < int'(d[7:4]));
            e.b = (nf < int'(d[3:0]));
            exp_q.push_back(e);
            adv  <= na;
            fcnt <= nf;
            cyc  <= cyc + 1;
            {dr, dg, db} <= d;
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic start(input mode_e m);
        if0.mode  = m;
        if0.pause = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        if0.mode  = HUE;
        if0.pause = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        tests++;
        if ({if1.rgb_r, if1.rgb_g, if1.rgb_b} !== 3'b111) begin
            fails++;
            $display("FAIL reset_al_rgb: got %b expected 111", {if1.rgb_r, if1.rgb_g, if1.rgb_b});
        end
        tests++;
        if (if1.cycle_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: got %b expected 0", if1.cycle_done);
        end
        tests++;
        if ({if0.rgb_r, if0.rgb_g, if0.rgb_b} !== 3'b000) begin
            fails++;
            $display("FAIL reset_rgb: got %b expected 000", {if0.rgb_r, if0.rgb_g, if0.rgb_b});
        end
    endtask

    task automatic test_hue_startup();
        exp_t e;
        int   hr = 0;
        int   hg = 0;
        int   hb = 0;
        start(HUE);
        #1;
        tests++;
        if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if1.rgb_r, if1.rgb_g, if1.rgb_b} !== 6'b000111) begin
            fails++;
            $display("FAIL startup_cycle0: got %b expected 000111",
                     {if0.rgb_r, if0.rgb_g, if0.rgb_b, if1.rgb_r, if1.rgb_g, if1.rgb_b});
        end
        repeat (31) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL startup_sb: no expected entry at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done} !== {e.r, e.g, e.b, e.done}) begin
                    fails++;
                    $display("FAIL startup_sb cycle %0d: got %b expected %b", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done}, {e.r, e.g, e.b, e.done});
                end
                tests++;
                if ({if1.rgb_r, if1.rgb_g, if1.rgb_b, if1.cycle_done} !== {~e.r, ~e.g, ~e.b, e.done}) begin
                    fails++;
                    $display("FAIL startup_sb_al cycle %0d: got %b expected %b", cyc,
                             {if1.rgb_r, if1.rgb_g, if1.rgb_b, if1.cycle_done}, {~e.r, ~e.g, ~e.b, e.done});
                end
            end
            if (cyc < 16) begin
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b} !== 3'b000) begin
                    fails++;
                    $display("FAIL startup_frame1 cycle %0d: got %b expected 000", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b});
                end
            end else begin
                hr += int'(if0.rgb_r);
                hg += int'(if0.rgb_g);
                hb += int'(if0.rgb_b);
            end
        end
        tests++;
        if (hr != 15 || hg != 1 || hb != 0) begin
            fails++;
            $display("FAIL startup_frame2 high counts: got R%0d G%0d B%0d expected R15 G1 B0", hr, hg, hb);
        end
    endtask

    task automatic test_hue_freerun();
        exp_t e;
        int   done_t[$];
        start(HUE);
        repeat (2900) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL freerun_sb: no expected entry at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done} !== {e.r, e.g, e.b, e.done}) begin
                    fails++;
                    $display("FAIL freerun_sb cycle %0d: got %b expected %b", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done}, {e.r, e.g, e.b, e.done});
                end
                tests++;
                if ({if1.rgb_r, if1.rgb_g, if1.rgb_b, if1.cycle_done} !== {~e.r, ~e.g, ~e.b, e.done}) begin
                    fails++;
                    $display("FAIL freerun_sb_al cycle %0d: got %b expected %b", cyc,
                             {if1.rgb_r, if1.rgb_g, if1.rgb_b, if1.cycle_done}, {~e.r, ~e.g, ~e.b, e.done});
                end
            end
            if (if0.cycle_done === 1'b1) done_t.push_back(cyc);
        end
        tests++;
        if (done_t.size() != 3) begin
            fails++;
            $display("FAIL freerun_done_count: got %0d expected 3", done_t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (done_t[i] != 960 * (i + 1)) begin
                    fails++;
                    $display("FAIL freerun_done_time %0d: got %0d expected %0d", i, done_t[i], 960 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        int   done_t[$];
        start(HUE);
        repeat (1500) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL pause_sb: no expected entry at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done} !== {e.r, e.g, e.b, e.done}) begin
                    fails++;
                    $display("FAIL pause_sb cycle %0d: got %b expected %b", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done}, {e.r, e.g, e.b, e.done});
                end
            end
            if (if0.cycle_done === 1'b1) done_t.push_back(cyc);
            if (cyc == 100) if0.pause = 1'b1;
            if (cyc == 600) if0.pause = 1'b0;
        end
        tests++;
        if (done_t.size() != 1) begin
            fails++;
            $display("FAIL pause_done_count: got %0d expected 1", done_t.size());
        end else begin
            tests++;
            if (done_t[0] != 1460) begin
                fails++;
                $display("FAIL pause_done_time: got %0d expected 1460", done_t[0]);
            end
        end
    endtask

    task automatic test_off();
        exp_t e;
        int   done_t[$];
        start(HUE);
        repeat (1000) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL off_sb: no expected entry at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done} !== {e.r, e.g, e.b, e.done}) begin
                    fails++;
                    $display("FAIL off_sb cycle %0d: got %b expected %b", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done}, {e.r, e.g, e.b, e.done});
                end
            end
            if (cyc >= 38 && cyc <= 47) begin
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b} !== {(cyc != 47), 2'b00}) begin
                    fails++;
                    $display("FAIL off_current_frame cycle %0d: got %b expected %b", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b}, {(cyc != 47), 2'b00});
                end
            end else if (cyc >= 48) begin
                tests++;
                if ({if1.rgb_r, if1.rgb_g, if1.rgb_b} !== 3'b111) begin
                    fails++;
                    $display("FAIL off_inactive cycle %0d: got %b expected 111", cyc,
                             {if1.rgb_r, if1.rgb_g, if1.rgb_b});
                end
            end
            if (if0.cycle_done === 1'b1) done_t.push_back(cyc);
            if (cyc == 37) if0.mode = OFF;
        end
        tests++;
        if (done_t.size() != 1 || done_t[0] != 960) begin
            fails++;
            $display("FAIL off_done: got %0d pulses first at %0d expected 1 at 960",
                     done_t.size(), (done_t.size() > 0) ? done_t[0] : -1);
        end
    endtask

    task automatic test_breathe_reset();
        exp_t e;
        start(BREATHE);
        repeat (33) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL breathe_sb: no expected entry at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done} !== {e.r, e.g, e.b, e.done}) begin
                    fails++;
                    $display("FAIL breathe_sb cycle %0d: got %b expected %b", cyc,
                             {if0.rgb_r, if0.rgb_g, if0.rgb_b, if0.cycle_done}, {e.r, e.g, e.b, e.done});
                end
            end
        end
        tests++;
        if ({if0.rgb_r, if0.rgb_g, if0.rgb_b} !== 3'b111) begin
            fails++;
            $display("FAIL breathe_on_before_reset: got %b expected 111", {if0.rgb_r, if0.rgb_g, if0.rgb_b});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({if0.rgb_r, if0.rgb_g, if0.rgb_b, if1.rgb_r, if1.rgb_g, if1.rgb_b, if0.cycle_done} !== 7'b0001110) begin
            fails++;
            $display("FAIL breathe_async_reset: got %b expected 0001110",
                     {if0.rgb_r, if0.rgb_g, if0.rgb_b, if1.rgb_r, if1.rgb_g, if1.rgb_b, if0.cycle_done});
        end
        test_hue_startup();
    endtask

    initial begin
        if0.mode  = HUE;
        if0.pause = 1'b0;
        test_reset();
        test_hue_startup();
        hold_reset();
        test_hue_freerun();
        hold_reset();
        test_pause();
        hold_reset();
        test_off();
        hold_reset();
        test_breathe_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hsv_pwm_cycler.md
HSV_PWM_CYCLER -- requirements
Module: hsv_pwm_cycler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter PERIOD_MS, default 1000, duration of one full colour-wheel revolution in ms.
REQ-003 SHALL have parameter PWM_BITS, default 8, duty resolution; STEPS = 2^PWM_BITS, MAX = STEPS-1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, where 1 drives LED-on as logic 0.
REQ-005 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port mode  input  2  operating mode: 0 HUE, 1 BREATHE, 2 HOLD, 3 OFF.
REQ-008 SHALL have port pause  input  1  freezes phase advance while high.
REQ-009 SHALL have ports RGB_R / RGB_G / RGB_B  output  1 each  PWM LED drive.
REQ-010 SHALL have port cycle_done  output  1  one-clock pulse on phase wrap.

Function
REQ-011 SHALL derive localparam TICK_DIV = (CLK_HZ/1000*PERIOD_MS)/(6*STEPS), truncated; elaboration SHALL fail if TICK_DIV < 1.
REQ-012 SHALL run a prescaler counting 0..TICK_DIV-1; a step tick SHALL fire on the count of TICK_DIV-1, then the prescaler wraps to 0.
REQ-013 SHALL hold a phase: sector state S0..S5 plus a PWM_BITS index; each step tick SHALL increment the index; on index MAX the index SHALL wrap to 0 and the sector SHALL advance (S5 -> S0).
REQ-014 SHALL assert cycle_done for exactly one clock on the tick moving S5/MAX -> S0/0.
REQ-015 SHALL freeze prescaler, phase and cycle_done generation while pause=1; PWM SHALL keep running.
REQ-016 In HUE, with rise=index and fall=MAX-index, duties (R,G,B) SHALL be: S0 (MAX,rise,0), S1 (fall,MAX,0), S2 (0,MAX,rise), S3 (0,fall,MAX), S4 (rise,0,MAX), S5 (MAX,0,fall).
REQ-017 In BREATHE, all three duties SHALL equal rise in S0/S2/S4 and fall in S1/S3/S5.
REQ-018 In HOLD, the phase SHALL freeze (as pause) and duties SHALL remain at their HUE values for the frozen phase.
REQ-019 In OFF, all duties SHALL be 0; the phase SHALL keep advancing.
REQ-020 SHALL run a free-running PWM_BITS frame counter, 0..MAX then wrapping to 0.
REQ-021 Each channel SHALL be on while frame counter < latched duty: duty 0 = never on; duty MAX = on for MAX of STEPS clocks.
REQ-022 Latched duties SHALL update only on the frame-counter wrap edge (counter MAX -> 0); mode or phase changes mid-frame SHALL NOT alter the current frame.
REQ-023 Outputs SHALL be registered; the physical level SHALL equal on XOR ACTIVE_LOW.
REQ-024 Simultaneous step tick and frame wrap: the latched duty SHALL be computed from the phase before that tick.

Reset
REQ-025 While rst_n=0, without requiring a clock edge: prescaler, frame counter and index SHALL be 0; sector SHALL be S0; latched duties SHALL be 0; cycle_done SHALL be 0; RGB_* SHALL be at the inactive level (= ACTIVE_LOW).
REQ-026 After rst_n deasserts, the first frame SHALL output all-off; operation SHALL start from phase S0/0.

Structure
REQ-027 Package hsv_pwm_pkg SHALL hold the sector enum (S0..S5) and the mode enum (HUE, BREATHE, HOLD, OFF).
REQ-028 Sub-module pwm_channel (PWM_BITS, ACTIVE_LOW params; inputs duty and frame count; duty latch and output register) SHALL be instantiated three times.

Verification
All scenarios use CLK_HZ=96000, PERIOD_MS=10, PWM_BITS=4 (TICK_DIV=10, STEPS=16, 960 clocks per revolution) unless stated.
REQ-029 SHALL cover: rst_n=0 with ACTIVE_LOW=1 -> RGB_*=1 and cycle_done=0 immediately, with no clock edge.
REQ-030 SHALL cover: HUE, ACTIVE_LOW=0, after release -> clocks 0-15 all low; frame 2 R high 15/16 clocks, G high 1/16 clocks, B 0.
REQ-031 SHALL cover: HUE free-run -> cycle_done high for one clock at clocks 960, 1920, 2880 after release.
REQ-032 SHALL cover: pause=1 for 500 clocks starting at clock 100 -> index unchanged during pause; first cycle_done at clock 1460.
REQ-033 SHALL cover: mode switched to OFF at clock 5 of a frame -> remaining clocks of that frame unchanged; from the next frame all outputs inactive; phase still advances (cycle_done still at 960).
REQ-034 SHALL cover: rst_n pulsed low mid-frame in BREATHE -> outputs inactive asynchronously; after release the sequence repeats exactly as in the REQ-030 timing.
